// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// mem_port_arbiter_pkg : shared types and constants for the memory port arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

    localparam int MEM_ARB_LINE_W       = 30;
    localparam int MEM_ARB_DATA_W       = 32;
    localparam int MEM_ARB_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_DATA = 2'd2
    } MemOwner;

    function automatic logic is_load(input logic [3:0] wEnable);
        return (wEnable == 4'b0000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// mem_port_arbiter_if : fetch, load/store and BRAM port bundle of the arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int LINE_W = 30,
    parameter int DATA_W = 32
);
    logic              flush;
    logic              ifReq;
    logic [LINE_W-1:0] ifLine;
    logic              ifGnt;
    logic              ifRValid;
    logic [DATA_W-1:0] ifRData;
    logic              dReq;
    logic [LINE_W-1:0] dLine;
    logic [3:0]        dWEnable;
    logic [DATA_W-1:0] dWData;
    logic              dGnt;
    logic              dRValid;
    logic [DATA_W-1:0] dRData;
    logic [LINE_W-1:0] memLine;
    logic [3:0]        memWEnable;
    logic [DATA_W-1:0] memWData;
    logic [DATA_W-1:0] memRData;

    // Core and BRAM side
    modport master (
        output flush, ifReq, ifLine, dReq, dLine, dWEnable, dWData, memRData,
        input  ifGnt, ifRValid, ifRData, dGnt, dRValid, dRData,
               memLine, memWEnable, memWData
    );

    // Arbiter side
    modport slave (
        input  flush, ifReq, ifLine, dReq, dLine, dWEnable, dWData, memRData,
        output ifGnt, ifRValid, ifRData, dGnt, dRValid, dRData,
               memLine, memWEnable, memWData
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one BRAM port between fetch and load/store,
// DATA-priority with a starvation escape for fetch.  Rev 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = MEM_ARB_STARVE_LIMIT
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mem_port_arbiter_if.slave   bus
);

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

    MemOwner          r_respOwner;
    logic [CNT_W-1:0] r_starveCnt;

    logic w_ifOk;
    logic w_forceIf;
    logic w_ifGnt;
    logic w_dGnt;

    always_comb begin
        w_ifOk    = bus.ifReq && !bus.flush;
        w_forceIf = w_ifOk && (r_starveCnt == c_LIMIT);
        w_ifGnt   = 1'b0;
        w_dGnt    = 1'b0;
        if (w_forceIf) begin
            w_ifGnt = 1'b1;
        end else if (bus.dReq) begin
            w_dGnt = 1'b1;
        end else if (w_ifOk) begin
            w_ifGnt = 1'b1;
        end
    end

    always_comb begin
        bus.memLine    = bus.dLine;
        bus.memWEnable = 4'b0000;
        bus.memWData   = bus.dWData;
        if (w_ifGnt) begin
            bus.memLine = bus.ifLine;
        end else if (w_dGnt) begin
            bus.memWEnable = bus.dWEnable;
        end
    end

    assign bus.ifGnt    = w_ifGnt;
    assign bus.dGnt     = w_dGnt;
    // A flush arriving while a fetch is in flight drops that response
    assign bus.ifRValid = (r_respOwner == OWNER_IF) && !bus.flush;
    assign bus.dRValid  = (r_respOwner == OWNER_DATA);
    assign bus.ifRData  = bus.memRData;
    assign bus.dRData   = bus.memRData;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_respOwner <= OWNER_NONE;
            r_starveCnt <= '0;
        end else begin
            if (w_ifGnt) begin
                r_respOwner <= OWNER_IF;
            end else if (w_dGnt && is_load(bus.dWEnable)) begin
                r_respOwner <= OWNER_DATA;
            end else begin
                r_respOwner <= OWNER_NONE;
            end

            if (w_ifGnt || !bus.ifReq) begin
                r_starveCnt <= '0;
            end else if (w_dGnt && (r_starveCnt != c_LIMIT)) begin
                r_starveCnt <= r_starveCnt + c_ONE;
            end
        end
    end

endmodule

`default_nettype wire
